// File: rtl/id_hazard_fwd_unit_pkg.sv
// Shared definitions for the decode-stage hazard/forwarding unit: HI/LO op
// encodings, register-file constants and the packed to-ID forwarding bus.
package id_hazard_fwd_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // we + waddr + wdata; lines up with the ex/mem/wb to-ID buses.
  localparam int FWD_BUS_W = 1 + REG_W + DATA_W;

  typedef enum logic [1:0] {
    HILO_NONE = 2'b00,
    HILO_MUL  = 2'b01,
    HILO_DIV  = 2'b10,
    HILO_RSVD = 2'b11
  } hilo_op_e;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
  } fwd_src_t;

  // Reserved encoding behaves like "no HI/LO operation".
  function automatic logic is_hilo_issue(hilo_op_e op);
    return (op == HILO_MUL) || (op == HILO_DIV);
  endfunction

endpackage

// File: rtl/id_hazard_fwd_unit_fwd_select.sv
// Priority forwarding select for one source operand: lowest-index matching
// producer wins, register zero is hard-wired and never raises a hazard.
module id_hazard_fwd_unit_fwd_select
  import id_hazard_fwd_unit_pkg::*;
#(
  parameter int NUM_FWD = 3
) (
  input  logic [REG_W-1:0]     addr,
  input  fwd_src_t [NUM_FWD-1:0] srcs,
  input  logic [NUM_FWD-1:0]   pending,
  input  logic [DATA_W-1:0]    rf_data,
  output logic [DATA_W-1:0]    val,
  output logic                 haz
);

  logic found;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    val   = rf_data;
    haz   = 1'b0;
    found = 1'b0;
    if (addr == REG_ZERO) begin
      val = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && srcs[i].we && (srcs[i].waddr == addr)) begin
          found = 1'b1;
          val   = srcs[i].wdata;
          haz   = pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_fwd_unit.sv
// Decode-stage operand/hazard unit: instruction hold across ID stalls,
// prioritised operand forwarding, HI/LO busy countdown and stall counter.
module id_hazard_fwd_unit
  import id_hazard_fwd_unit_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      stall_id,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_W-1:0]         inst_sram_rdata,
  output logic [DATA_W-1:0]         inst,
  input  logic [REG_W-1:0]          rs,
  input  logic [REG_W-1:0]          rt,
  input  logic                      use_rs,
  input  logic                      use_rt,
  input  logic [1:0]                hilo_op,
  input  logic                      hilo_read,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [REG_W*NUM_FWD-1:0]  fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic [DATA_W-1:0]         rs_val,
  output logic [DATA_W-1:0]         rt_val,
  output logic                      stallreq,
  output logic                      hilo_busy,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int HILO_W  = $clog2(LAT_MAX + 1);

  logic                   held;
  logic [DATA_W-1:0]      inst_hold;
  logic [HILO_W-1:0]      hilo_cnt;
  fwd_src_t [NUM_FWD-1:0] srcs;
  hilo_op_e               op;
  logic                   rs_haz;
  logic                   rt_haz;
  logic                   hilo_hazard;
  logic                   issue;

  assign op = hilo_op_e'(hilo_op);

  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) begin
      srcs[i] = '{we:    fwd_we[i],
                  waddr: fwd_waddr[REG_W*i +: REG_W],
                  wdata: fwd_wdata[DATA_W*i +: DATA_W]};
    end
  end

  id_hazard_fwd_unit_fwd_select #(.NUM_FWD(NUM_FWD)) u_sel_rs (
    .addr    (rs),
    .srcs    (srcs),
    .pending (fwd_pending),
    .rf_data (rf_rdata1),
    .val     (rs_val),
    .haz     (rs_haz)
  );

  id_hazard_fwd_unit_fwd_select #(.NUM_FWD(NUM_FWD)) u_sel_rt (
    .addr    (rt),
    .srcs    (srcs),
    .pending (fwd_pending),
    .rf_data (rf_rdata2),
    .val     (rt_val),
    .haz     (rt_haz)
  );

  assign hilo_busy   = (hilo_cnt != '0);
  assign hilo_hazard = hilo_busy & (hilo_read | is_hilo_issue(op));
  assign stallreq    = id_valid & ~flush &
                       ((use_rs & rs_haz) | (use_rt & rt_haz) | hilo_hazard);
  assign issue       = id_valid & ~stallreq & ~stall_id & ~flush;

  // The hold register captures the fetch data on the first stalled edge only;
  // the decoder keeps seeing it until the edge that ends the stall.
  assign inst = held ? inst_hold : inst_sram_rdata;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  // The hold data register is reset too, keeping inst free of X after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held      <= 1'b0;
      inst_hold <= '0;
    end else if (flush || !stall_id) begin
      held <= 1'b0;
    end else if (!held) begin
      held      <= 1'b1;
      inst_hold <= inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo_cnt <= '0;
    end else if (issue && (op == HILO_MUL)) begin
      hilo_cnt <= HILO_W'(MUL_LAT);
    end else if (issue && (op == HILO_DIV)) begin
      hilo_cnt <= HILO_W'(DIV_LAT);
    end else if (hilo_busy) begin
      hilo_cnt <= hilo_cnt - HILO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stallreq && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Directed bench for id_hazard_fwd_unit: expectations are queued as stimulus
// is applied and drained against the DUT outputs at the falling edge.
module tb_id_hazard_fwd_unit;

  localparam int NUM_FWD = 3;

  logic        clk;
  logic        resetn;
  logic        stall_id;
  logic        flush;
  logic        id_valid;
  logic [31:0] inst_sram_rdata;
  logic [31:0] inst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        use_rs;
  logic        use_rt;
  logic [1:0]  hilo_op;
  logic        hilo_read;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [NUM_FWD-1:0]    fwd_we;
  logic [5*NUM_FWD-1:0]  fwd_waddr;
  logic [32*NUM_FWD-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]    fwd_pending;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stallreq;
  logic        hilo_busy;
  logic [31:0] stall_cycles;

  id_hazard_fwd_unit #(
    .NUM_FWD(NUM_FWD), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(32)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall_id        (stall_id),
    .flush           (flush),
    .id_valid        (id_valid),
    .inst_sram_rdata (inst_sram_rdata),
    .inst            (inst),
    .rs              (rs),
    .rt              (rt),
    .use_rs          (use_rs),
    .use_rt          (use_rt),
    .hilo_op         (hilo_op),
    .hilo_read       (hilo_read),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .fwd_we          (fwd_we),
    .fwd_waddr       (fwd_waddr),
    .fwd_wdata       (fwd_wdata),
    .fwd_pending     (fwd_pending),
    .rs_val          (rs_val),
    .rt_val          (rt_val),
    .stallreq        (stallreq),
    .hilo_busy       (hilo_busy),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_RS, S_RT, S_STALL, S_INST, S_BUSY, S_CNT} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_RS:    return rs_val;
      S_RT:    return rt_val;
      S_STALL: return {31'd0, stallreq};
      S_INST:  return inst;
      S_BUSY:  return {31'd0, hilo_busy};
      default: return stall_cycles;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Drains every queued expectation against the current DUT outputs.
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic p);
    fwd_we[i]           = we;
    fwd_waddr[5*i +: 5] = a;
    fwd_wdata[32*i +: 32] = d;
    fwd_pending[i]      = p;
  endtask

  task automatic clear_srcs();
    fwd_we      = '0;
    fwd_waddr   = '0;
    fwd_wdata   = '0;
    fwd_pending = '0;
  endtask

  initial begin
    resetn          = 1'b0;
    stall_id        = 1'b0;
    flush           = 1'b0;
    id_valid        = 1'b0;
    inst_sram_rdata = 32'h1234_5678;
    rs              = '0;
    rt              = '0;
    use_rs          = 1'b0;
    use_rt          = 1'b0;
    hilo_op         = 2'b00;
    hilo_read       = 1'b0;
    rf_rdata1       = 32'hDEAD_0001;
    rf_rdata2       = 32'hBEEF_0002;
    clear_srcs();

    // Reset state: not held, counters idle.
    #2;
    expect_val("rst_inst", S_INST, 32'h1234_5678);
    expect_val("rst_stall", S_STALL, 32'd0);
    expect_val("rst_busy", S_BUSY, 32'd0);
    expect_val("rst_cnt", S_CNT, 32'd0);
    check();
    @(posedge clk);
    #1 resetn = 1'b1;

    // Younger ready source beats older pending source for the same register.
    id_valid = 1'b1;
    set_src(0, 1'b1, 5'd5, 32'h11, 1'b0);
    set_src(2, 1'b1, 5'd5, 32'h22, 1'b1);
    rs = 5'd5; use_rs = 1'b1;
    rt = 5'd7; use_rt = 1'b1;
    expect_val("prio_rs", S_RS, 32'h11);
    expect_val("prio_rt_rf", S_RT, 32'hBEEF_0002);
    expect_val("prio_stall", S_STALL, 32'd0);
    sample(); step();

    // Middle source wins when source 0 targets another register.
    clear_srcs();
    set_src(0, 1'b1, 5'd3, 32'h33, 1'b0);
    set_src(1, 1'b1, 5'd8, 32'h55, 1'b0);
    set_src(2, 1'b1, 5'd8, 32'h66, 1'b1);
    rs = 5'd3; rt = 5'd8;
    expect_val("mid_rs", S_RS, 32'h33);
    expect_val("mid_rt", S_RT, 32'h55);
    expect_val("mid_stall", S_STALL, 32'd0);
    sample(); step();

    // Register zero is never forwarded nor hazarded.
    clear_srcs();
    set_src(0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b1);
    rs = 5'd0; rt = 5'd0;
    expect_val("zero_rs", S_RS, 32'd0);
    expect_val("zero_rt", S_RT, 32'd0);
    expect_val("zero_stall", S_STALL, 32'd0);
    sample(); step();

    // Load-use: pending producer stalls, then resolves.
    clear_srcs();
    set_src(0, 1'b1, 5'd8, 32'hDEAD, 1'b1);
    rs = 5'd0; use_rs = 1'b0;
    rt = 5'd8; use_rt = 1'b1;
    expect_val("lu_stall", S_STALL, 32'd1);
    sample(); step();

    set_src(0, 1'b1, 5'd8, 32'hABCD, 1'b0);
    expect_val("lu_rt", S_RT, 32'hABCD);
    expect_val("lu_release", S_STALL, 32'd0);
    expect_val("lu_cnt", S_CNT, 32'd1);
    sample(); step();

    set_src(0, 1'b1, 5'd8, 32'hABCD, 1'b1);
    use_rt = 1'b0;
    expect_val("lu_unused", S_STALL, 32'd0);
    sample(); step();

    use_rt = 1'b1; flush = 1'b1;
    expect_val("lu_flush", S_STALL, 32'd0);
    sample(); step();

    flush = 1'b0; id_valid = 1'b0;
    expect_val("lu_invalid", S_STALL, 32'd0);
    expect_val("lu_cnt2", S_CNT, 32'd1);
    sample(); step();

    // Instruction hold across a 3-cycle ID stall.
    clear_srcs();
    use_rt = 1'b0;
    stall_id = 1'b1;
    inst_sram_rdata = 32'h3C01_0001;
    expect_val("hold_first", S_INST, 32'h3C01_0001);
    sample(); step();
    inst_sram_rdata = 32'h0;
    expect_val("hold_c2", S_INST, 32'h3C01_0001);
    sample(); step();
    expect_val("hold_c3", S_INST, 32'h3C01_0001);
    sample(); step();
    stall_id = 1'b0;
    expect_val("hold_release", S_INST, 32'h3C01_0001);
    sample(); step();
    expect_val("hold_live", S_INST, 32'h0);
    sample(); step();

    // Flush during a stall drops the hold.
    stall_id = 1'b1;
    inst_sram_rdata = 32'hAAAA_0001;
    sample(); step();
    flush = 1'b1;
    inst_sram_rdata = 32'hAAAA_0002;
    expect_val("flush_held", S_INST, 32'hAAAA_0001);
    sample(); step();
    flush = 1'b0;
    inst_sram_rdata = 32'hAAAA_0003;
    expect_val("flush_cleared", S_INST, 32'hAAAA_0003);
    sample(); step();
    stall_id = 1'b0;
    sample(); step();

    // Fresh counters for the HI/LO sequence.
    resetn = 1'b0;
    #1 resetn = 1'b1;
    step();

    // div issues, one unrelated instruction, then mflo waits out the countdown.
    id_valid = 1'b1;
    hilo_op = 2'b10;
    expect_val("div_issue_stall", S_STALL, 32'd0);
    expect_val("div_idle_busy", S_BUSY, 32'd0);
    sample(); step();
    hilo_op = 2'b00;
    expect_val("div_busy", S_BUSY, 32'd1);
    expect_val("div_gap_stall", S_STALL, 32'd0);
    sample(); step();
    hilo_read = 1'b1;
    for (int k = 0; k < 31; k++) begin
      expect_val("div_mflo_stall", S_STALL, 32'd1);
      sample(); step();
    end
    expect_val("div_mflo_go", S_STALL, 32'd0);
    expect_val("div_mflo_busy", S_BUSY, 32'd0);
    expect_val("div_stall_cnt", S_CNT, 32'd31);
    sample(); step();

    // Back-to-back mult serialises behind the first.
    hilo_read = 1'b0;
    hilo_op = 2'b01;
    expect_val("mul1_go", S_STALL, 32'd0);
    sample(); step();
    expect_val("mul2_wait_a", S_STALL, 32'd1);
    sample(); step();
    expect_val("mul2_wait_b", S_STALL, 32'd1);
    sample(); step();
    expect_val("mul2_go", S_STALL, 32'd0);
    expect_val("mul_stall_cnt", S_CNT, 32'd33);
    sample(); step();
    hilo_op = 2'b00;
    id_valid = 1'b0;
    step(); step();

    // Async reset with the divide countdown at 10.
    id_valid = 1'b1;
    hilo_op = 2'b10;
    step();
    id_valid = 1'b0;
    hilo_op = 2'b00;
    repeat (22) step();
    expect_val("pre_rst_busy", S_BUSY, 32'd1);
    expect_val("pre_rst_cnt", S_CNT, 32'd33);
    sample();
    #1 resetn = 1'b0;
    #1;
    expect_val("async_rst_busy", S_BUSY, 32'd0);
    expect_val("async_rst_cnt", S_CNT, 32'd0);
    check();
    resetn = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
